float_div: RTL

- Iterative IEEE-754 double-precision divider: result = num1 / num2.
- It is the inverse-operation companion to the pipelined FP multiplier in the FP arithmetic cluster, and uses the same operand and result encoding.
- Multi-cycle, one operation in flight at a time, fixed latency.
- Output is a registered result with a one-cycle completion strobe.

---
 rtl/float_div.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/float_div.sv
// rtl/float_div.sv - iterative IEEE-754 double-precision divider, fixed 59-cycle latency
module float_div #(
    parameter int BIT          = 64,
    parameter int EXPONENT_LEN = 11,
    parameter int MANTISSA_LEN = 52,
    parameter int BIAS         = 1023
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [BIT-1:0] num1,
    input  logic [BIT-1:0] num2,
    input  logic           valid,
    output logic           ready,
    output logic [BIT-1:0] result,
    output logic           result_valid
);
    localparam int SIG_LEN = MANTISSA_LEN + 1;
    localparam int Q_LEN   = MANTISSA_LEN + 3;
    localparam int EXP_W   = EXPONENT_LEN + 2;
    localparam int CNT_W   = $clog2(Q_LEN);

    localparam logic [EXPONENT_LEN-1:0] EXP_MAX   = '1;
    localparam logic signed [EXP_W-1:0] EXP_INF   = EXP_W'((1 << EXPONENT_LEN) - 1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO  = '0;
    localparam logic [1:0]              SP_NONE   = 2'd0;
    localparam logic [1:0]              SP_NAN    = 2'd1;
    localparam logic [1:0]              SP_INF    = 2'd2;
    localparam logic [1:0]              SP_ZERO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t                    r_state, w_next;
    logic [BIT-1:0]            r_num1, r_num2, r_result;
    logic                      r_result_valid, r_sign;
    logic signed [EXP_W-1:0]   r_exp;
    logic [SIG_LEN:0]          r_rem;
    logic [SIG_LEN-1:0]        r_div;
    // Leading quotient bit is always 1 and shifts out the top; what remains is fraction, guard, round.
    logic [Q_LEN-2:0]          r_quo;
    logic [CNT_W-1:0]          r_cnt;
    logic [1:0]                r_special;
    logic                      w_ready;

    logic [EXPONENT_LEN-1:0]   w_e1, w_e2;
    logic [MANTISSA_LEN-1:0]   w_f1, w_f2;
    logic [SIG_LEN-1:0]        w_sig1, w_sig2;
    logic                      w_adj, w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
    logic signed [EXP_W-1:0]   w_exp, w_exp_rnd;
    logic [1:0]                w_special;
    logic                      w_ge, w_inc, w_carry;
    logic [SIG_LEN:0]          w_rem_next;
    logic [MANTISSA_LEN:0]     w_fsum;
    logic [BIT-1:0]            w_result;

    assign w_e1    = r_num1[BIT-2 -: EXPONENT_LEN];
    assign w_e2    = r_num2[BIT-2 -: EXPONENT_LEN];
    assign w_f1    = r_num1[MANTISSA_LEN-1:0];
    assign w_f2    = r_num2[MANTISSA_LEN-1:0];
    assign w_sig1  = {1'b1, w_f1};
    assign w_sig2  = {1'b1, w_f2};
    assign w_adj   = w_sig1 < w_sig2;
    assign w_exp   = {2'b00, w_e1} - {2'b00, w_e2} + EXP_W'(BIAS) - EXP_W'(w_adj);
    assign w_nan1  = (w_e1 == EXP_MAX) && (w_f1 != '0);
    assign w_nan2  = (w_e2 == EXP_MAX) && (w_f2 != '0);
    assign w_inf1  = (w_e1 == EXP_MAX) && (w_f1 == '0);
    assign w_inf2  = (w_e2 == EXP_MAX) && (w_f2 == '0);
    assign w_zero1 = (w_e1 == '0);
    assign w_zero2 = (w_e2 == '0);

    always_comb begin
        w_special = SP_NONE;
        if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2))
            w_special = SP_NAN;
        else if (w_inf1 || w_zero2)
            w_special = SP_INF;
        else if (w_zero1 || w_inf2)
            w_special = SP_ZERO;
    end

    assign w_ge       = r_rem >= {1'b0, r_div};
    assign w_rem_next = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // Round to nearest even on guard (r_quo[1]), round (r_quo[0]) and sticky remainder.
    assign w_inc     = r_quo[1] & (r_quo[0] | (r_rem != '0) | r_quo[2]);
    assign w_fsum    = {1'b0, r_quo[Q_LEN-2:2]} + {{MANTISSA_LEN{1'b0}}, w_inc};
    assign w_carry   = w_fsum[MANTISSA_LEN];
    assign w_exp_rnd = r_exp + EXP_W'(w_carry);

    always_comb begin
        w_result = {r_sign, w_exp_rnd[EXPONENT_LEN-1:0], w_fsum[MANTISSA_LEN-1:0]};
        case (r_special)
            SP_NAN:  w_result = {1'b0, EXP_MAX, 1'b1, {(MANTISSA_LEN-1){1'b0}}};
            SP_INF:  w_result = {r_sign, EXP_MAX, {MANTISSA_LEN{1'b0}}};
            SP_ZERO: w_result = {r_sign, {(BIT-1){1'b0}}};
            default: if (w_exp_rnd >= EXP_INF)
                         w_result = {r_sign, EXP_MAX, {MANTISSA_LEN{1'b0}}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (valid) w_next = S_UNPACK;
            end
            S_UNPACK: w_next = S_DIVIDE;
            S_DIVIDE: if (r_cnt == CNT_W'(Q_LEN - 1)) w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_num1 <= '0; r_num2 <= '0; r_result <= '0; r_result_valid <= 1'b0;
            r_sign <= 1'b0; r_exp <= '0; r_rem <= '0; r_div <= '0; r_quo <= '0;
            r_cnt <= '0; r_special <= SP_NONE;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (valid) begin
                    r_num1 <= num1;
                    r_num2 <= num2;
                end
                S_UNPACK: begin
                    r_sign    <= r_num1[BIT-1] ^ r_num2[BIT-1];
                    r_exp     <= w_exp;
                    r_rem     <= w_adj ? {w_sig1, 1'b0} : {1'b0, w_sig1};
                    r_div     <= w_sig2;
                    r_quo     <= '0;
                    r_cnt     <= '0;
                    r_special <= w_special;
                end
                S_DIVIDE: begin
                    r_quo <= {r_quo[Q_LEN-3:0], w_ge};
                    r_rem <= w_rem_next << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_NORM: if (r_special == SP_NONE) begin
                    if (r_exp >= EXP_INF)       r_special <= SP_INF;
                    else if (r_exp <= EXP_ZERO) r_special <= SP_ZERO;
                end
                S_ROUND: begin
                    r_result       <= w_result;
                    r_result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready        = w_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
endmodule
